// File: rtl/zap_thumb_fetch_aligner_pkg.sv
// Shared constants for the Thumb fetch aligner.
//  - FSM state encodings (legacy localparam style).
//  - Thumb BL prefix/suffix opcode fields (hw[15:11]).
//  - CPSR T bit index.
package zap_thumb_fetch_aligner_pkg;

  // CPSR bit that selects Thumb state.
  localparam int unsigned T = 5;

  // Aligner buffer states.
  localparam logic [1:0] EMPTY   = 2'd0;  // no buffered word
  localparam logic [1:0] HAVE_LO = 2'd1;  // lower half (or whole ARM word) next
  localparam logic [1:0] HAVE_HI = 2'd2;  // only the upper half left

  // Thumb BL pair identification on hw[15:11].
  localparam logic [4:0] T_BL_PREFIX = 5'b11110;
  localparam logic [4:0] T_BL_SUFFIX = 5'b11111;

endpackage

// File: rtl/zap_thumb_halfword_sel.sv
// Combinational halfword picker.
//  word_i      32-bit fetch word
//  slot_i      halfword address bit (pc[1])
//  halfword_o  selected halfword, honouring BIG_ENDIAN
module zap_thumb_halfword_sel #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] word_i,
  input  logic        slot_i,
  output logic [15:0] halfword_o
);

  // Big-endian flips which half sits at the lower address.
  logic hi_sel;
  assign hi_sel     = slot_i ^ BIG_ENDIAN;
  assign halfword_o = hi_sel ? word_i[31:16] : word_i[15:0];

endmodule

// File: rtl/zap_thumb_fetch_aligner.sv
// Fetch-to-decode aligner. In Thumb state each 32-bit fetch word is buffered and its halfwords
// are issued one per cycle with their own PC; in ARM state words pass through with one cycle of
// latency. BL prefix/suffix pairs are kept atomic with respect to IRQ/FIQ.
// Ports:
//  i_clk, i_reset                    clock, synchronous active-high reset
//  i_cpsr_ff                         CPSR; T bit selects Thumb state (sampled at accept)
//  i_flush, i_stall                  pipeline flush / decoder back-pressure
//  i_fetch_word/pc/valid, o_fetch_ready   fetch handshake
//  i_irq, i_fiq                      interrupt requests
//  o_instruction, o_instruction_valid, o_pc, o_irq, o_fiq   registered decoder-side outputs
module zap_thumb_fetch_aligner
  import zap_thumb_fetch_aligner_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_cpsr_ff,
  input  logic        i_flush,
  input  logic        i_stall,
  input  logic [31:0] i_fetch_word,
  input  logic [31:0] i_fetch_pc,
  input  logic        i_fetch_valid,
  output logic        o_fetch_ready,
  input  logic        i_irq,
  input  logic        i_fiq,
  output logic [31:0] o_instruction,
  output logic        o_instruction_valid,
  output logic [31:0] o_pc,
  output logic        o_irq,
  output logic        o_fiq
);

  logic [1:0]  state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [31:0] pc_q, pc_d;        // address of the next unit to issue from the buffer
  logic        thumb_q, thumb_d;
  logic        bl_lock_q, bl_lock_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic        valid_q, valid_d;
  logic        irq_q, irq_d;
  logic        fiq_q, fiq_d;

  logic        thumb_in, accept, from_buf;
  logic [31:0] src_word, src_pc;
  logic        src_thumb;
  logic [15:0] src_hw;
  logic        is_prefix, is_suffix, int_block;

  logic unused_cpsr;
  assign unused_cpsr = ^{i_cpsr_ff[31:T+1], i_cpsr_ff[T-1:0]};

  assign thumb_in      = i_cpsr_ff[T];
  assign o_fetch_ready = !i_flush && (state_q == EMPTY || (state_q == HAVE_HI && !i_stall));
  assign accept        = i_fetch_valid && o_fetch_ready;

  // Issue from the buffer when it holds something, otherwise straight from the accepted word.
  assign from_buf  = (state_q != EMPTY);
  assign src_word  = from_buf ? word_q  : i_fetch_word;
  assign src_pc    = from_buf ? pc_q    : i_fetch_pc;
  assign src_thumb = from_buf ? thumb_q : thumb_in;

  zap_thumb_halfword_sel #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_hw_sel (
    .word_i     (src_word),
    .slot_i     (src_pc[1]),
    .halfword_o (src_hw)
  );

  assign is_prefix = src_thumb && (src_hw[15:11] == T_BL_PREFIX);
  assign is_suffix = src_thumb && (src_hw[15:11] == T_BL_SUFFIX);
  // Both halves of a BL pair, and anything while the pair is open, go out without interrupts.
  assign int_block = bl_lock_q || is_prefix || is_suffix;

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    pc_d      = pc_q;
    thumb_d   = thumb_q;
    bl_lock_d = bl_lock_q;
    instr_d   = instr_q;
    opc_d     = opc_q;
    valid_d   = valid_q;
    irq_d     = irq_q;
    fiq_d     = fiq_q;

    if (i_flush) begin
      state_d   = EMPTY;
      bl_lock_d = 1'b0;
      valid_d   = 1'b0;
      irq_d     = 1'b0;
      fiq_d     = 1'b0;
    end else if (i_stall) begin
      // Accept under stall is only possible in EMPTY: park the word, outputs hold.
      if (accept) begin
        word_d  = i_fetch_word;
        pc_d    = i_fetch_pc;
        thumb_d = thumb_in;
        state_d = (thumb_in && i_fetch_pc[1]) ? HAVE_HI : HAVE_LO;
      end
    end else if (from_buf || accept) begin
      valid_d = 1'b1;
      instr_d = src_thumb ? {16'd0, src_hw} : src_word;
      opc_d   = src_pc;
      irq_d   = i_irq && !int_block;
      fiq_d   = i_fiq && !int_block;
      if (is_prefix) begin
        bl_lock_d = 1'b1;
      end else if (is_suffix) begin
        bl_lock_d = 1'b0;
      end

      if (src_thumb && !src_pc[1]) begin
        state_d = HAVE_HI;
        word_d  = src_word;
        pc_d    = src_pc + 32'd2;
        thumb_d = 1'b1;
      end else begin
        state_d = EMPTY;
      end

      // Refill from HAVE_HI: the new word's first unit issues next cycle.
      if (accept && from_buf) begin
        word_d  = i_fetch_word;
        pc_d    = i_fetch_pc;
        thumb_d = thumb_in;
        state_d = (thumb_in && i_fetch_pc[1]) ? HAVE_HI : HAVE_LO;
      end
    end else begin
      valid_d = 1'b0;
      irq_d   = 1'b0;
      fiq_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= EMPTY;
      word_q    <= '0;
      pc_q      <= '0;
      thumb_q   <= 1'b0;
      bl_lock_q <= 1'b0;
      instr_q   <= '0;
      opc_q     <= '0;
      valid_q   <= 1'b0;
      irq_q     <= 1'b0;
      fiq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      pc_q      <= pc_d;
      thumb_q   <= thumb_d;
      bl_lock_q <= bl_lock_d;
      instr_q   <= instr_d;
      opc_q     <= opc_d;
      valid_q   <= valid_d;
      irq_q     <= irq_d;
      fiq_q     <= fiq_d;
    end
  end

  assign o_instruction       = instr_q;
  assign o_instruction_valid = valid_q;
  assign o_pc                = opc_q;
  assign o_irq               = irq_q;
  assign o_fiq               = fiq_q;

endmodule

// File: tb/tb_zap_thumb_fetch_aligner.sv
// Directed bench for zap_thumb_fetch_aligner; a little-endian and a big-endian instance share
// stimulus, the big-endian one is checked only on the basic Thumb sequence.
module tb_zap_thumb_fetch_aligner;

  logic        clk = 1'b0;
  logic        reset, flush, stall, fetch_valid, irq, fiq;
  logic [31:0] cpsr, fetch_word, fetch_pc;

  logic        ready_le, valid_le, irq_le, fiq_le;
  logic [31:0] instr_le, pc_le;
  logic        ready_be, valid_be, irq_be, fiq_be;
  logic [31:0] instr_be, pc_be;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  zap_thumb_fetch_aligner #(.BIG_ENDIAN(1'b0)) u_dut_le (
    .i_clk               (clk),
    .i_reset             (reset),
    .i_cpsr_ff           (cpsr),
    .i_flush             (flush),
    .i_stall             (stall),
    .i_fetch_word        (fetch_word),
    .i_fetch_pc          (fetch_pc),
    .i_fetch_valid       (fetch_valid),
    .o_fetch_ready       (ready_le),
    .i_irq               (irq),
    .i_fiq               (fiq),
    .o_instruction       (instr_le),
    .o_instruction_valid (valid_le),
    .o_pc                (pc_le),
    .o_irq               (irq_le),
    .o_fiq               (fiq_le)
  );

  zap_thumb_fetch_aligner #(.BIG_ENDIAN(1'b1)) u_dut_be (
    .i_clk               (clk),
    .i_reset             (reset),
    .i_cpsr_ff           (cpsr),
    .i_flush             (flush),
    .i_stall             (stall),
    .i_fetch_word        (fetch_word),
    .i_fetch_pc          (fetch_pc),
    .i_fetch_valid       (fetch_valid),
    .o_fetch_ready       (ready_be),
    .i_irq               (irq),
    .i_fiq               (fiq),
    .o_instruction       (instr_be),
    .o_instruction_valid (valid_be),
    .o_pc                (pc_be),
    .o_irq               (irq_be),
    .o_fiq               (fiq_be)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one issued LE instruction.
  task automatic check_out(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                           input logic v, input logic ir);
    check({tag, ".instr"}, instr_le, ins);
    check({tag, ".pc"}, pc_le, pc);
    check({tag, ".valid"}, {31'd0, valid_le}, {31'd0, v});
    check({tag, ".irq"}, {31'd0, irq_le}, {31'd0, ir});
  endtask

  task automatic drive(input logic [31:0] w, input logic [31:0] pc);
    fetch_word  = w;
    fetch_pc    = pc;
    fetch_valid = 1'b1;
  endtask

  task automatic check_ready(input string tag, input logic exp);
    #1;
    check(tag, {31'd0, ready_le}, {31'd0, exp});
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0; fetch_valid = 1'b0; irq = 1'b0; fiq = 1'b0;
    cpsr = 32'h20; fetch_word = '0; fetch_pc = '0;
    step(); step();
    reset = 1'b0;
    check_out("reset", 32'h0, 32'h0, 1'b0, 1'b0);
    check("reset.fiq", {31'd0, fiq_le}, 32'd0);
    check_ready("reset.ready", 1'b1);

    // 1: Thumb word, both halves, LE and BE orders.
    drive(32'h4301_2000, 32'h100);
    step(); fetch_valid = 1'b0;
    check_out("t1.lo", 32'h2000, 32'h100, 1'b1, 1'b0);
    check("t1.be.lo", instr_be, 32'h4301);
    check("t1.be.pc", pc_be, 32'h100);
    step();
    check_out("t1.hi", 32'h4301, 32'h102, 1'b1, 1'b0);
    check("t1.be.hi", instr_be, 32'h2000);
    check("t1.be.pc2", pc_be, 32'h102);
    step();
    check("t1.empty.valid", {31'd0, valid_le}, 32'd0);
    check("t1.empty.hold", instr_le, 32'h4301);

    // 2: pc[1]=1 issues only the upper half.
    drive(32'h4301_2000, 32'h102);
    step(); fetch_valid = 1'b0;
    check_out("t2.hi", 32'h4301, 32'h102, 1'b1, 1'b0);
    check_ready("t2.ready", 1'b1);
    step();
    check("t2.after", {31'd0, valid_le}, 32'd0);

    // 3: BL pair under a held IRQ/FIQ, next word refilled back-to-back.
    irq = 1'b1; fiq = 1'b1;
    drive(32'hF800_F000, 32'h200);
    step();
    check_out("t3.prefix", 32'hF000, 32'h200, 1'b1, 1'b0);
    check("t3.prefix.fiq", {31'd0, fiq_le}, 32'd0);
    drive(32'h4301_2000, 32'h204);
    step(); fetch_valid = 1'b0;
    check_out("t3.suffix", 32'hF800, 32'h202, 1'b1, 1'b0);
    step();
    check_out("t3.next", 32'h2000, 32'h204, 1'b1, 1'b1);
    check("t3.next.fiq", {31'd0, fiq_le}, 32'd1);
    irq = 1'b0; fiq = 1'b0;
    step();
    check_out("t3.next2", 32'h4301, 32'h206, 1'b1, 1'b0);
    step();
    check_out("t3.empty", 32'h4301, 32'h206, 1'b0, 1'b0);

    // 4: stall in HAVE_HI, release then back-to-back refill.
    drive(32'h4301_2000, 32'h400);
    step(); fetch_valid = 1'b0;
    stall = 1'b1;
    drive(32'h1111_2222, 32'h404);
    for (int i = 0; i < 3; i++) begin
      check_ready("t4.stall.ready", 1'b0);
      step();
      check_out("t4.stall", 32'h2000, 32'h400, 1'b1, 1'b0);
    end
    stall = 1'b0;
    check_ready("t4.release.ready", 1'b1);
    step(); fetch_valid = 1'b0;
    check_out("t4.hi", 32'h4301, 32'h402, 1'b1, 1'b0);
    step();
    check_out("t4.new.lo", 32'h2222, 32'h404, 1'b1, 1'b0);
    step();
    check_out("t4.new.hi", 32'h1111, 32'h406, 1'b1, 1'b0);
    step();
    check("t4.empty", {31'd0, valid_le}, 32'd0);

    // 5: flush in HAVE_LO with a dangling BL prefix lock and a competing fetch.
    drive(32'h4301_F000, 32'h500);
    step();
    check_out("t5.prefix", 32'hF000, 32'h500, 1'b1, 1'b0);
    drive(32'h5555_6666, 32'h504);
    step();
    check_out("t5.hi", 32'h4301, 32'h502, 1'b1, 1'b0);
    flush = 1'b1;
    drive(32'h7777_8888, 32'h508);
    check_ready("t5.flush.ready", 1'b0);
    step(); flush = 1'b0; fetch_valid = 1'b0;
    check("t5.flush.valid", {31'd0, valid_le}, 32'd0);
    check_ready("t5.empty.ready", 1'b1);
    irq = 1'b1;
    drive(32'h0000_2000, 32'h600);
    step(); fetch_valid = 1'b0;
    check_out("t5.unlocked", 32'h2000, 32'h600, 1'b1, 1'b1);
    irq = 1'b0;
    step();
    check_out("t5.next", 32'h0000, 32'h602, 1'b1, 1'b0);
    step();

    // 6: ARM pass-through after a flush.
    flush = 1'b1; step(); flush = 1'b0;
    cpsr = 32'h0;
    drive(32'hE3A0_0001, 32'h0);
    step();
    drive(32'hE1A0_0000, 32'h4);
    check_out("t6.w0", 32'hE3A0_0001, 32'h0, 1'b1, 1'b0);
    check_ready("t6.ready", 1'b1);
    step(); fetch_valid = 1'b0;
    check_out("t6.w1", 32'hE1A0_0000, 32'h4, 1'b1, 1'b0);
    step();
    check("t6.empty", {31'd0, valid_le}, 32'd0);

    // Top-of-memory Thumb word.
    flush = 1'b1; step(); flush = 1'b0;
    cpsr = 32'h20;
    drive(32'h4301_2000, 32'hFFFF_FFFC);
    step(); fetch_valid = 1'b0;
    check_out("wrap.lo", 32'h2000, 32'hFFFF_FFFC, 1'b1, 1'b0);
    step();
    check_out("wrap.hi", 32'h4301, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step();

    // Reset mid-operation drops the buffered half.
    drive(32'h4301_2000, 32'h700);
    step(); fetch_valid = 1'b0;
    reset = 1'b1;
    step(); reset = 1'b0;
    check_out("rst.mid", 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    check_out("rst.after", 32'h0, 32'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
